alu_regfile_wb: RTL and testbench

- Operand source and result sink for `alu`: supplies `read_data_1`/`read_data_2` and absorbs `write_data`/`zero_f` back into architectural registers.
- Contains the integer register array (x0 hardwired to zero), a one-entry writeback stage register with read bypass, and a busy scoreboard. The scoreboard tells issue logic when a source operand is still awaiting an ALU result.
- Sits between decode/issue and `alu` in the core datapath.

---
 rtl/alu_regfile_wb.sv | 85 ++++++++
 tb/tb_alu_regfile_wb.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/alu_regfile_wb.sv
// Register file for the ALU, with x0 tied to zero. It has a one-entry writeback
// stage that read ports can bypass, and a per-register busy scoreboard for issue.
module alu_regfile_wb #(
  parameter int unsigned N    = 32,
  parameter int unsigned REGS = 32,
  parameter int unsigned AW   = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  output logic [N-1:0]  read_data_1,
  output logic [N-1:0]  read_data_2,
  output logic          rs1_busy,
  output logic          rs2_busy,
  input  logic          issue_valid,
  input  logic [AW-1:0] issue_rd,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic [N-1:0]  write_data,
  input  logic          zero_f,
  output logic          zero_flag,
  output logic          wb_pending
);

  logic [N-1:0]    regs [REGS];
  logic            stage_valid;
  logic [AW-1:0]   stage_addr;
  logic [N-1:0]    stage_data;
  logic [REGS-1:0] busy;
  logic [REGS-1:0] busy_nxt;

  // Writeback stage capture, then commit one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_addr  <= '0;
      stage_data  <= '0;
      zero_flag   <= 1'b0;
      for (int i = 0; i < int'(REGS); i++) regs[i] <= '0;
    end else begin
      if (wb_valid) begin
        stage_valid <= (wb_addr != '0);
        stage_addr  <= wb_addr;
        stage_data  <= write_data;
        zero_flag   <= zero_f;
      end else begin
        stage_valid <= 1'b0;
      end
      if (stage_valid) regs[stage_addr] <= stage_data;
    end
  end

  // A new producer takes priority over a retiring one for the same register.
  always_comb begin
    busy_nxt = busy;
    if (wb_valid)    busy_nxt[wb_addr]  = 1'b0;
    if (issue_valid) busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  // Reads see the staged result, never the incoming write_data, so no loop forms through the ALU.
  function automatic logic [N-1:0] read_port(input logic [AW-1:0] addr);
    logic [N-1:0] r;
    r = regs[addr];
    if (addr == '0)                              r = '0;
    else if (stage_valid && stage_addr == addr) r = stage_data;
    return r;
  endfunction

  always_comb begin
    read_data_1 = read_port(rs1_addr);
    read_data_2 = read_port(rs2_addr);
  end

  assign rs1_busy   = busy[rs1_addr];
  assign rs2_busy   = busy[rs2_addr];
  assign wb_pending = stage_valid;

endmodule

// File: tb/tb_alu_regfile_wb.sv
// Directed test of alu_regfile_wb: reset, bypass/commit timing, x0 handling,
// back-to-back writebacks, scoreboard set-vs-clear priority, and mid-operation reset.
module tb_alu_regfile_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  rs1_addr, rs2_addr, issue_rd, wb_addr;
  logic [31:0] read_data_1, read_data_2, write_data;
  logic        rs1_busy, rs2_busy, issue_valid, wb_valid, zero_f, zero_flag, wb_pending;

  int n_checks = 0;
  int n_fail   = 0;

  alu_regfile_wb #(.N(32), .REGS(32), .AW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .write_data(write_data), .zero_f(zero_f),
    .zero_flag(zero_flag), .wb_pending(wb_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Hold reset with every input driven nonzero
    rst_n = 1'b0;
    rs1_addr = 5'd5; rs2_addr = 5'd5; issue_valid = 1'b1; issue_rd = 5'd5;
    wb_valid = 1'b1; wb_addr = 5'd5; write_data = 32'hFFFF_FFFF; zero_f = 1'b1;
    #1;
    chk("rst_rd1_async", read_data_1, 32'h0);
    tick(); tick();
    chk("rst_rd1", read_data_1, 32'h0);
    chk("rst_rd2", read_data_2, 32'h0);
    chk("rst_busy1", 32'(rs1_busy), 32'h0);
    chk("rst_pending", 32'(wb_pending), 32'h0);
    chk("rst_zflag", 32'(zero_flag), 32'h0);
    issue_valid = 1'b0; wb_valid = 1'b0; write_data = '0; zero_f = 1'b0;
    #2 rst_n = 1'b1;
    tick();

    // Issue x3, then write it back
    rs1_addr = 5'd3; rs2_addr = 5'd0;
    issue_valid = 1'b1; issue_rd = 5'd3;
    tick();
    issue_valid = 1'b0;
    #1;
    chk("x3_busy_after_issue", 32'(rs1_busy), 32'h1);
    wb_valid = 1'b1; wb_addr = 5'd3; write_data = 32'hDEAD_BEEF; zero_f = 1'b0;
    #1;
    chk("x3_busy_capture_cycle", 32'(rs1_busy), 32'h1);
    chk("x3_no_comb_bypass", read_data_1, 32'h0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("x3_busy_cleared", 32'(rs1_busy), 32'h0);
    chk("x3_bypass", read_data_1, 32'hDEAD_BEEF);
    chk("x3_pending", 32'(wb_pending), 32'h1);
    chk("x3_zflag", 32'(zero_flag), 32'h0);
    tick();
    chk("x3_array", read_data_1, 32'hDEAD_BEEF);
    chk("x3_pending_done", 32'(wb_pending), 32'h0);

    // Writeback to x0 updates only zero_flag
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    wb_valid = 1'b1; wb_addr = 5'd0; write_data = 32'h1234_5678; zero_f = 1'b1;
    tick();
    wb_valid = 1'b0; zero_f = 1'b0;
    #1;
    chk("x0_read", read_data_1, 32'h0);
    chk("x0_pending", 32'(wb_pending), 32'h0);
    chk("x0_zflag", 32'(zero_flag), 32'h1);
    tick();
    chk("x0_read_later", read_data_2, 32'h0);
    chk("zflag_hold", 32'(zero_flag), 32'h1);

    // Back-to-back writebacks to x7, read on both ports
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    wb_valid = 1'b1; wb_addr = 5'd7; write_data = 32'h1;
    tick();
    write_data = 32'h2;
    #1;
    chk("x7_first_bypass", read_data_1, 32'h1);
    chk("x7_first_bypass_p2", read_data_2, 32'h1);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("x7_second_bypass", read_data_1, 32'h2);
    chk("x7_zflag", 32'(zero_flag), 32'h0);
    tick();
    chk("x7_array", read_data_2, 32'h2);
    chk("x7_pending_done", 32'(wb_pending), 32'h0);

    // Overwrite x3 while it is not busy, read via rs2
    rs2_addr = 5'd3;
    wb_valid = 1'b1; wb_addr = 5'd3; write_data = 32'h0000_0011;
    tick();
    wb_valid = 1'b0;
    tick();
    chk("x3_overwrite", read_data_2, 32'h0000_0011);
    chk("x3_overwrite_busy", 32'(rs2_busy), 32'h0);

    // Issue and capture x4 in the same cycle: the new producer keeps x4 busy
    rs1_addr = 5'd4;
    issue_valid = 1'b1; issue_rd = 5'd4;
    wb_valid = 1'b1; wb_addr = 5'd4; write_data = 32'h0000_00AA;
    tick();
    issue_valid = 1'b0; wb_valid = 1'b0;
    #1;
    chk("x4_busy_set_wins", 32'(rs1_busy), 32'h1);
    chk("x4_bypass", read_data_1, 32'h0000_00AA);
    tick();
    chk("x4_array", read_data_1, 32'h0000_00AA);
    chk("x4_still_busy", 32'(rs1_busy), 32'h1);

    // Reset while x9 is staged and busy
    rs1_addr = 5'd9; rs2_addr = 5'd4;
    issue_valid = 1'b1; issue_rd = 5'd9;
    wb_valid = 1'b1; wb_addr = 5'd9; write_data = 32'h0000_0055;
    tick();
    issue_valid = 1'b0; wb_valid = 1'b0;
    #1;
    chk("x9_staged", read_data_1, 32'h0000_0055);
    chk("x9_busy", 32'(rs1_busy), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("x9_rst_pending", 32'(wb_pending), 32'h0);
    chk("x9_rst_busy", 32'(rs1_busy), 32'h0);
    #1 rst_n = 1'b1;
    tick();
    chk("x9_after_rst", read_data_1, 32'h0);
    chk("x4_after_rst", read_data_2, 32'h0);
    chk("x4_busy_after_rst", 32'(rs2_busy), 32'h0);
    chk("pending_after_rst", 32'(wb_pending), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
